child_bank: RTL and testbench

Parametrised multi-channel capture bank. Each of CHANNELS input lanes samples a WIDTH-bit value on its valid strobe and keeps a saturating per-channel event count. A single-outstanding read port returns one channel's last sample, count and overflow flag, then clears that channel's count. It sits between a set of producer children and a register/CSR layer.

---
 rtl/child_bank.sv | 138 +++++++++++++
 tb/tb_child_bank.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/child_bank.sv
// child_bank: multi-channel capture bank with saturating per-lane event counts
// and a single-outstanding read port that returns and clears one lane.
// Optional feature macro: CHILD_BANK_MASK_EN adds the ch_mask per-lane enable port.
module child_bank #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 8,
  localparam int unsigned SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] a,
  input  logic [CHANNELS-1:0]       a_valid,
`ifdef CHILD_BANK_MASK_EN
  input  logic [CHANNELS-1:0]       ch_mask,
`endif
  input  logic                      rd_req,
  input  logic [SEL_W-1:0]          rd_sel,
  output logic                      rd_ack,
  output logic [WIDTH-1:0]          rd_data,
  output logic [CNT_W-1:0]          rd_count,
  output logic                      rd_ovf
);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e              state_q, state_d;
  logic                accept;
  logic [CHANNELS-1:0] lane_en;
  logic [CHANNELS-1:0] clr;

  logic [WIDTH-1:0]    hold_q [CHANNELS];
  logic [WIDTH-1:0]    hold_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q  [CHANNELS];
  logic [CNT_W-1:0]    cnt_d  [CHANNELS];
  logic [CHANNELS-1:0] ovf_q, ovf_d;

  logic [WIDTH-1:0]    sel_data;
  logic [CNT_W-1:0]    sel_cnt;
  logic                sel_ovf;

  logic [WIDTH-1:0]    rd_data_q;
  logic [CNT_W-1:0]    rd_count_q;
  logic                rd_ovf_q;

`ifdef CHILD_BANK_MASK_EN
  assign lane_en = a_valid & ch_mask;
`else
  assign lane_en = a_valid;
`endif

  // Read FSM next state; a request is only accepted from idle
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rd_req) begin
          accept  = 1'b1;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Select mux over pre-update lane state; out-of-range selects yield zeros and clear nothing
  always_comb begin
    clr      = '0;
    sel_data = '0;
    sel_cnt  = '0;
    sel_ovf  = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        clr[i]   = accept;
        sel_data = hold_q[i];
        sel_cnt  = cnt_q[i];
        sel_ovf  = ovf_q[i];
      end
    end
  end

  // Per-lane capture, saturating count and read-clear (a same-cycle capture counts as 1)
  always_comb begin
    ovf_d = ovf_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      hold_d[i] = hold_q[i];
      cnt_d[i]  = cnt_q[i];
      if (lane_en[i]) hold_d[i] = a[i*WIDTH +: WIDTH];
      if (clr[i]) begin
        cnt_d[i] = lane_en[i] ? CNT_W'(1) : '0;
        ovf_d[i] = 1'b0;
      end else if (lane_en[i]) begin
        if (&cnt_q[i]) ovf_d[i] = 1'b1;
        else           cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Lane state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        hold_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      ovf_q <= '0;
    end else begin
      hold_q <= hold_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // FSM state and read response registers; response values persist until the next accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rd_data_q  <= '0;
      rd_count_q <= '0;
      rd_ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rd_data_q  <= sel_data;
        rd_count_q <= sel_cnt;
        rd_ovf_q   <= sel_ovf;
      end
    end
  end

  assign rd_ack   = (state_q == StResp);
  assign rd_data  = rd_data_q;
  assign rd_count = rd_count_q;
  assign rd_ovf   = rd_ovf_q;

endmodule

// File: tb/tb_child_bank.sv
// tb_child_bank: directed self-checking bench for child_bank (3 lanes, 8-bit data, 4-bit counts).
module tb_child_bank;

  localparam int unsigned W  = 8;
  localparam int unsigned CH = 3;
  localparam int unsigned CW = 4;

  logic            clk;
  logic            rst;
  logic [CH*W-1:0] a;
  logic [CH-1:0]   a_valid;
  logic [CH-1:0]   ch_mask;
  logic            rd_req;
  logic [1:0]      rd_sel;
  logic            rd_ack;
  logic [W-1:0]    rd_data;
  logic [CW-1:0]   rd_count;
  logic            rd_ovf;

  int n_cmp = 0;
  int n_err = 0;

  child_bank #(
    .WIDTH    (W),
    .CHANNELS (CH),
    .CNT_W    (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .a_valid  (a_valid),
`ifdef CHILD_BANK_MASK_EN
    .ch_mask  (ch_mask),
`endif
    .rd_req   (rd_req),
    .rd_sel   (rd_sel),
    .rd_ack   (rd_ack),
    .rd_data  (rd_data),
    .rd_count (rd_count),
    .rd_ovf   (rd_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs are driven and outputs sampled 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int lane, input logic [W-1:0] d);
    a_valid[lane] = 1'b1;
    a[lane*W +: W] = d;
    tick();
    a_valid = '0;
  endtask

  // Full read transaction; r = {ack, data, count, ovf} in the response cycle
  task automatic do_read(input logic [1:0] sel, input logic [CH-1:0] v,
                         input logic [CH*W-1:0] d, output logic [13:0] r);
    rd_req  = 1'b1;
    rd_sel  = sel;
    a_valid = v;
    a       = d;
    tick();
    rd_req  = 1'b0;
    a_valid = '0;
    r = {rd_ack, rd_data, rd_count, rd_ovf};
    tick();
  endtask

  task automatic test_reset();
    logic [13:0] r;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({rd_ack, rd_data, rd_count, rd_ovf} !== 14'h0) begin
      n_err++;
      $display("FAIL reset_initial: got %h, expected %h", {rd_ack, rd_data, rd_count, rd_ovf}, 14'h0);
    end
    tick();
    @(negedge clk) rst = 1'b0;
    tick();
    strobe(0, 8'h5A);
    rd_req = 1'b1;
    rd_sel = 2'd0;
    tick();
    rd_req = 1'b0;
    n_cmp++;
    if ({rd_ack, rd_data, rd_count, rd_ovf} !== {1'b1, 8'h5A, 4'd1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_pre_read: got %h, expected %h",
               {rd_ack, rd_data, rd_count, rd_ovf}, {1'b1, 8'h5A, 4'd1, 1'b0});
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({rd_ack, rd_data, rd_count, rd_ovf} !== 14'h0) begin
      n_err++;
      $display("FAIL reset_midread: got %h, expected %h", {rd_ack, rd_data, rd_count, rd_ovf}, 14'h0);
    end
    @(negedge clk) rst = 1'b0;
    tick();
    n_cmp++;
    if (rd_ack !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_ack: got %b, expected 0", rd_ack);
    end
    do_read(2'd0, '0, '0, r);
    n_cmp++;
    if (r !== {1'b1, 8'h00, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_first_read: got %h, expected %h", r, {1'b1, 8'h00, 4'd0, 1'b0});
    end
  endtask

  task automatic test_basic_capture();
    logic [13:0] r;
    strobe(2, 8'h11);
    strobe(2, 8'h22);
    strobe(2, 8'h33);
    do_read(2'd2, '0, '0, r);
    n_cmp++;
    if (r !== {1'b1, 8'h33, 4'd3, 1'b0}) begin
      n_err++;
      $display("FAIL basic_read: got %h, expected %h", r, {1'b1, 8'h33, 4'd3, 1'b0});
    end
    do_read(2'd2, '0, '0, r);
    n_cmp++;
    if (r !== {1'b1, 8'h33, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL basic_reread: got %h, expected %h", r, {1'b1, 8'h33, 4'd0, 1'b0});
    end
  endtask

  task automatic test_saturation();
    logic [13:0] r;
    for (int i = 0; i < 20; i++) strobe(1, 8'(i + 1));
    do_read(2'd1, '0, '0, r);
    n_cmp++;
    if (r !== {1'b1, 8'h14, 4'd15, 1'b1}) begin
      n_err++;
      $display("FAIL sat_read: got %h, expected %h", r, {1'b1, 8'h14, 4'd15, 1'b1});
    end
    do_read(2'd1, '0, '0, r);
    n_cmp++;
    if (r !== {1'b1, 8'h14, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL sat_reread: got %h, expected %h", r, {1'b1, 8'h14, 4'd0, 1'b0});
    end
  endtask

  task automatic test_simultaneous();
    logic [13:0] r;
    for (int i = 0; i < 5; i++) strobe(0, 8'(i + 1));
    do_read(2'd0, 3'b001, {16'h0, 8'hAA}, r);
    n_cmp++;
    if (r !== {1'b1, 8'h05, 4'd5, 1'b0}) begin
      n_err++;
      $display("FAIL simul_read: got %h, expected %h", r, {1'b1, 8'h05, 4'd5, 1'b0});
    end
    do_read(2'd0, '0, '0, r);
    n_cmp++;
    if (r !== {1'b1, 8'hAA, 4'd1, 1'b0}) begin
      n_err++;
      $display("FAIL simul_next: got %h, expected %h", r, {1'b1, 8'hAA, 4'd1, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] r;
    int acks;
    strobe(2, 8'h44);
    strobe(2, 8'h55);
    acks   = 0;
    rd_req = 1'b1;
    rd_sel = 2'd2;
    tick();
    acks += int'(rd_ack);
    n_cmp++;
    if ({rd_ack, rd_data, rd_count, rd_ovf} !== {1'b1, 8'h55, 4'd2, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_first: got %h, expected %h",
               {rd_ack, rd_data, rd_count, rd_ovf}, {1'b1, 8'h55, 4'd2, 1'b0});
    end
    tick();
    acks += int'(rd_ack);
    rd_req = 1'b0;
    n_cmp++;
    if ({rd_ack, rd_data, rd_count, rd_ovf} !== {1'b0, 8'h55, 4'd2, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_held: got %h, expected %h",
               {rd_ack, rd_data, rd_count, rd_ovf}, {1'b0, 8'h55, 4'd2, 1'b0});
    end
    tick();
    acks += int'(rd_ack);
    n_cmp++;
    if (acks != 1) begin
      n_err++;
      $display("FAIL b2b_ack_count: got %0d, expected 1", acks);
    end
    do_read(2'd2, '0, '0, r);
    n_cmp++;
    if (r !== {1'b1, 8'h55, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_after: got %h, expected %h", r, {1'b1, 8'h55, 4'd0, 1'b0});
    end
  endtask

  task automatic test_out_of_range();
    logic [13:0] r;
    a_valid = 3'b111;
    a       = {8'h72, 8'h71, 8'h70};
    tick();
    a_valid = '0;
    do_read(2'd3, '0, '0, r);
    n_cmp++;
    if (r !== {1'b1, 8'h00, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL oor_read: got %h, expected %h", r, {1'b1, 8'h00, 4'd0, 1'b0});
    end
    for (int i = 0; i < 3; i++) begin
      do_read(2'(i), '0, '0, r);
      n_cmp++;
      if (r !== {1'b1, 8'(8'h70 + i), 4'd1, 1'b0}) begin
        n_err++;
        $display("FAIL oor_lane%0d: got %h, expected %h", i, r, {1'b1, 8'(8'h70 + i), 4'd1, 1'b0});
      end
    end
  endtask

  task automatic test_mask();
    logic [13:0] r;
    logic [13:0] exp2;
    ch_mask = 3'b011;
    a       = {8'h82, 8'h81, 8'h80};
    a_valid = 3'b111;
    tick();
    tick();
    a_valid = '0;
    ch_mask = 3'b111;
`ifdef CHILD_BANK_MASK_EN
    exp2 = {1'b1, 8'h72, 4'd0, 1'b0};
`else
    exp2 = {1'b1, 8'h82, 4'd2, 1'b0};
`endif
    for (int i = 0; i < 2; i++) begin
      do_read(2'(i), '0, '0, r);
      n_cmp++;
      if (r !== {1'b1, 8'(8'h80 + i), 4'd2, 1'b0}) begin
        n_err++;
        $display("FAIL mask_lane%0d: got %h, expected %h", i, r, {1'b1, 8'(8'h80 + i), 4'd2, 1'b0});
      end
    end
    do_read(2'd2, '0, '0, r);
    n_cmp++;
    if (r !== exp2) begin
      n_err++;
      $display("FAIL mask_lane2: got %h, expected %h", r, exp2);
    end
  endtask

  initial begin
    rst     = 1'b0;
    a       = '0;
    a_valid = '0;
    ch_mask = 3'b111;
    rd_req  = 1'b0;
    rd_sel  = '0;
    test_reset();
    test_basic_capture();
    test_saturation();
    test_simultaneous();
    test_back_to_back();
    test_out_of_range();
    test_mask();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
